// File: rtl/fpga_olvds_pkg.sv
// Shared types and default 7:1 link patterns for the multi-lane LVDS transmitter.
package fpga_olvds_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_TRAIN} olvds_tx_st_t;

    // Source of the word reloaded into the lane shift registers at a load slot.
    typedef enum logic [1:0] {LD_IDLE, LD_DATA, LD_TRAIN} olvds_ld_sel_t;

    localparam logic [6:0] DEF_CLK_PAT   = 7'b1100011;
    localparam logic [6:0] DEF_TRAIN_PAT = 7'b1110000;

endpackage

// File: rtl/fpga_olvds_tx_if.sv
// Parallel word stream into the LVDS transmitter (valid/ready).
interface fpga_olvds_tx_if #(
    parameter int unsigned Width = 28
);
    logic [Width-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/fpga_olvds.sv
// Differential output buffer; behavioural stand-in for the vendor TLVDS_OBUF.
module fpga_olvds (
    input  logic in_i,
    output logic pad_p_o,
    output logic pad_n_o
);
    assign pad_p_o = in_i;
    assign pad_n_o = ~in_i;
endmodule

// File: rtl/fpga_olvds_tx_lane.sv
// One serial lane: parallel-load shift register, registered pad bit, LVDS buffer.
module fpga_olvds_tx_lane #(
    parameter int unsigned Width = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] word_i,
    output logic             pad_p_o,
    output logic             pad_n_o
);
    logic [Width-1:0] sreg_q, sreg_d;
    logic             bit_q, bit_d;

    // Bit 0 goes straight to the pad flop so it appears the cycle after the load slot.
    always_comb begin
        if (load_i) begin
            bit_d  = word_i[0];
            sreg_d = word_i >> 1;
        end else begin
            bit_d  = sreg_q[0];
            sreg_d = sreg_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            bit_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            bit_q  <= bit_d;
        end
    end

    fpga_olvds u_obuf (
        .in_i    (bit_q),
        .pad_p_o (pad_p_o),
        .pad_n_o (pad_n_o)
    );
endmodule

// File: rtl/fpga_olvds_tx.sv
// Multi-lane LVDS transmitter: word-boundary FSM, idle/training modes, forwarded clock lane.
module fpga_olvds_tx
    import fpga_olvds_pkg::*;
#(
    parameter int unsigned          NLANES      = 4,
    parameter int unsigned          SER_RATIO   = 7,
    parameter logic [SER_RATIO-1:0] CLK_PAT     = DEF_CLK_PAT,
    parameter logic [SER_RATIO-1:0] IDLE_PAT    = '0,
    parameter logic [SER_RATIO-1:0] TRAIN_PAT   = DEF_TRAIN_PAT,
    parameter int unsigned          TRAIN_WORDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              train_req_i,
    fpga_olvds_tx_if.slave    in_if,
    output logic              training_o,
    output logic              underflow_o,
    output logic [15:0]       ufl_cnt_o,
    output logic [NLANES-1:0] lvds_p_o,
    output logic [NLANES-1:0] lvds_n_o,
    output logic              lvds_clk_p_o,
    output logic              lvds_clk_n_o
);
    localparam int unsigned CntW = $clog2(SER_RATIO);
    localparam int unsigned TcW  = $clog2(TRAIN_WORDS + 1);

    olvds_tx_st_t    st_q, st_d;
    olvds_ld_sel_t   ld_sel;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [TcW-1:0]  tcnt_q, tcnt_d;
    logic [15:0]     ufl_cnt_q, ufl_cnt_d;
    logic            pend_q, pend_d, training_q, training_d;
    logic            load, in_ready, underflow, train_start;
    logic [SER_RATIO-1:0] clk_word;

    assign load = (bit_cnt_q == CntW'(SER_RATIO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) st_q <= ST_IDLE;
        else        st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        if (load) begin
            case (st_q)
                ST_IDLE:  if (en_i) st_d = ST_DATA;
                ST_DATA: begin
                    if (!en_i)       st_d = ST_IDLE;
                    else if (pend_q) st_d = (TRAIN_WORDS == 1) ? ST_DATA : ST_TRAIN;
                end
                ST_TRAIN: begin
                    if (!en_i)                               st_d = ST_IDLE;
                    else if (tcnt_q == TcW'(TRAIN_WORDS - 1)) st_d = ST_DATA;
                end
                default:  st_d = ST_IDLE;
            endcase
        end
    end

    // in_ready is a function of state and slot timing only; in_valid only steers the load mux.
    always_comb begin
        ld_sel      = LD_IDLE;
        in_ready    = 1'b0;
        underflow   = 1'b0;
        train_start = 1'b0;
        if (load && en_i) begin
            case (st_q)
                ST_DATA: begin
                    if (pend_q) begin
                        ld_sel      = LD_TRAIN;
                        train_start = 1'b1;
                    end else begin
                        in_ready = 1'b1;
                        if (in_if.in_valid) ld_sel = LD_DATA;
                        else                underflow = 1'b1;
                    end
                end
                ST_TRAIN: ld_sel = LD_TRAIN;
                default:  ld_sel = LD_IDLE;
            endcase
        end
    end

    always_comb begin
        bit_cnt_d  = load ? '0 : bit_cnt_q + CntW'(1);
        tcnt_d     = tcnt_q;
        if (train_start)                           tcnt_d = TcW'(1);
        else if (load && st_q == ST_TRAIN && en_i) tcnt_d = tcnt_q + TcW'(1);
        pend_d     = train_start ? 1'b0 : (pend_q | (train_req_i & (st_q != ST_TRAIN)));
        training_d = load ? (ld_sel == LD_TRAIN) : training_q;
        ufl_cnt_d  = (underflow && ufl_cnt_q != 16'hFFFF) ? ufl_cnt_q + 16'd1 : ufl_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            tcnt_q     <= '0;
            pend_q     <= 1'b0;
            training_q <= 1'b0;
            ufl_cnt_q  <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            tcnt_q     <= tcnt_d;
            pend_q     <= pend_d;
            training_q <= training_d;
            ufl_cnt_q  <= ufl_cnt_d;
        end
    end

    assign in_if.in_ready = in_ready;
    assign training_o     = training_q;
    assign underflow_o    = underflow;
    assign ufl_cnt_o      = ufl_cnt_q;

    for (genvar l = 0; l < NLANES; l++) begin : g_lane
        logic [SER_RATIO-1:0] word;
        always_comb begin
            case (ld_sel)
                LD_DATA:  word = in_if.in_data[l*SER_RATIO +: SER_RATIO];
                LD_TRAIN: word = TRAIN_PAT;
                default:  word = IDLE_PAT;
            endcase
        end
        fpga_olvds_tx_lane #(.Width(SER_RATIO)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_i  (load),
            .word_i  (word),
            .pad_p_o (lvds_p_o[l]),
            .pad_n_o (lvds_n_o[l])
        );
    end

    // The clock lane never waits on data: it tracks en alone.
    assign clk_word = en_i ? CLK_PAT : '0;

    fpga_olvds_tx_lane #(.Width(SER_RATIO)) u_clk_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .word_i  (clk_word),
        .pad_p_o (lvds_clk_p_o),
        .pad_n_o (lvds_clk_n_o)
    );
endmodule
